// File: rtl/sdram_cmd_arbiter_if.sv
// Bus bundle between the SDRAM command arbiter, the front end and the read/write engines.
// master = arbiter side, slave = surrounding logic (front end, engines, pins).
`ifndef SDRAM_CMD_NOP
`define SDRAM_CMD_NOP 3'b111
`endif
`ifndef SDRAM_CMD_ACT
`define SDRAM_CMD_ACT 3'b011
`endif
`ifndef SDRAM_CMD_WRITE
`define SDRAM_CMD_WRITE 3'b100
`endif
`ifndef SDRAM_CMD_PRE
`define SDRAM_CMD_PRE 3'b010
`endif
`ifndef SDRAM_CMD_AR
`define SDRAM_CMD_AR 3'b001
`endif

interface sdram_cmd_arbiter_if;
    localparam int unsigned CMD_W   = 3;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned BANK_W  = 2;
    localparam int unsigned COUNT_W = 16;

    logic               init_done;
    logic               app_read_req;
    logic               app_write_req;
    logic               rd_enable;
    logic               rd_idle;
    logic               rd_wait_for_refresh;
    logic [CMD_W-1:0]   rd_command;
    logic [ADDR_W-1:0]  rd_address;
    logic [BANK_W-1:0]  rd_bank;
    logic               wr_enable;
    logic               wr_idle;
    logic               wr_wait_for_refresh;
    logic [CMD_W-1:0]   wr_command;
    logic [ADDR_W-1:0]  wr_address;
    logic [BANK_W-1:0]  wr_bank;
    logic               auto_refresh;
    logic [CMD_W-1:0]   sdram_command;
    logic [ADDR_W-1:0]  sdram_address;
    logic [BANK_W-1:0]  sdram_bank;
    logic [1:0]         grant;
    logic [COUNT_W-1:0] refresh_count;
    logic               refresh_late;

    modport master (
        input  init_done, app_read_req, app_write_req,
        input  rd_idle, rd_wait_for_refresh, rd_command, rd_address, rd_bank,
        input  wr_idle, wr_wait_for_refresh, wr_command, wr_address, wr_bank,
        output rd_enable, wr_enable, auto_refresh,
        output sdram_command, sdram_address, sdram_bank, grant,
        output refresh_count, refresh_late
    );

    modport slave (
        output init_done, app_read_req, app_write_req,
        output rd_idle, rd_wait_for_refresh, rd_command, rd_address, rd_bank,
        output wr_idle, wr_wait_for_refresh, wr_command, wr_address, wr_bank,
        input  rd_enable, wr_enable, auto_refresh,
        input  sdram_command, sdram_address, sdram_bank, grant,
        input  refresh_count, refresh_late
    );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// Owns the SDRAM command bus: grants it to the read or write engine and interleaves
// precharge-all + auto-refresh. Define SDRAM_ARB_STATS_EN to build the refresh statistics.
module sdram_cmd_arbiter #(
    parameter int unsigned REFRESH_INTERVAL = 1560,
    parameter int unsigned T_RP             = 2,
    parameter int unsigned T_RFC            = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_cmd_arbiter_if.master  bus
);
    localparam int unsigned TIMER_W  = $clog2(REFRESH_INTERVAL + 1);
    localparam int unsigned WAIT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [1:0]  G_NONE   = 2'b00;
    localparam logic [1:0]  G_RD     = 2'b01;
    localparam logic [1:0]  G_WR     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT_RD, S_GRANT_WR, S_PRE_ALL, S_PRE_WAIT, S_REFRESH, S_RFC_WAIT
    } state_t;

    state_t              state, state_d;
    logic [WAIT_W-1:0]   wait_cnt, wait_d;
    logic [1:0]          resume, resume_d;
    logic                last_wr, last_wr_d;
    logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [1:0]          grant_q, grant_d;
    logic                refresh_done;
    logic                pending;
    logic [TIMER_W-1:0]  timer;
    logic                expire;
    logic                hold_rd, hold_wr;

    assign expire  = bus.init_done && (timer == '0);
    assign hold_rd = (resume == G_RD);
    assign hold_wr = (resume == G_WR);

    // Refresh interval timer; runs only once the SDRAM is initialised.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= TIMER_W'(REFRESH_INTERVAL - 1);
            pending <= 1'b0;
        end else begin
            if (bus.init_done) begin
                if (timer == '0) timer <= TIMER_W'(REFRESH_INTERVAL - 1);
                else             timer <= timer - 1'b1;
            end
            if (expire)            pending <= 1'b1;
            else if (refresh_done) pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            resume   <= G_NONE;
            last_wr  <= 1'b1;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            grant_q  <= G_NONE;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_d;
            resume   <= resume_d;
            last_wr  <= last_wr_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            grant_q  <= grant_d;
        end
    end

    always_comb begin
        state_d      = state;
        wait_d       = wait_cnt;
        resume_d     = resume;
        last_wr_d    = last_wr;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        grant_d      = G_NONE;
        refresh_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.init_done) begin
                    if (pending) begin
                        state_d  = S_PRE_ALL;
                        resume_d = G_NONE;
                    end else if (bus.app_read_req && (!bus.app_write_req || last_wr)) begin
                        state_d   = S_GRANT_RD;
                        rd_en_d   = 1'b1;
                        grant_d   = G_RD;
                        last_wr_d = 1'b0;
                    end else if (bus.app_write_req) begin
                        state_d   = S_GRANT_WR;
                        wr_en_d   = 1'b1;
                        grant_d   = G_WR;
                        last_wr_d = 1'b1;
                    end
                end
            end
            S_GRANT_RD: begin
                rd_en_d = 1'b1;
                grant_d = G_RD;
                if (pending && bus.rd_wait_for_refresh && bus.rd_idle) begin
                    state_d  = S_PRE_ALL;
                    resume_d = G_RD;
                    grant_d  = G_NONE;
                end else if (!bus.app_read_req) begin
                    rd_en_d = 1'b0;
                    if (bus.rd_idle) begin
                        state_d = S_IDLE;
                        grant_d = G_NONE;
                    end
                end
            end
            S_GRANT_WR: begin
                wr_en_d = 1'b1;
                grant_d = G_WR;
                if (pending && bus.wr_wait_for_refresh && bus.wr_idle) begin
                    state_d  = S_PRE_ALL;
                    resume_d = G_WR;
                    grant_d  = G_NONE;
                end else if (!bus.app_write_req) begin
                    wr_en_d = 1'b0;
                    if (bus.wr_idle) begin
                        state_d = S_IDLE;
                        grant_d = G_NONE;
                    end
                end
            end
            // Parked engine keeps its enable through the whole refresh sequence.
            S_PRE_ALL: begin
                rd_en_d = hold_rd;
                wr_en_d = hold_wr;
                state_d = S_PRE_WAIT;
                wait_d  = WAIT_W'(T_RP - 1);
            end
            S_PRE_WAIT: begin
                rd_en_d = hold_rd;
                wr_en_d = hold_wr;
                if (wait_cnt == '0) state_d = S_REFRESH;
                else                wait_d  = wait_cnt - 1'b1;
            end
            S_REFRESH: begin
                rd_en_d = hold_rd;
                wr_en_d = hold_wr;
                state_d = S_RFC_WAIT;
                wait_d  = WAIT_W'(T_RFC - 1);
            end
            S_RFC_WAIT: begin
                rd_en_d = hold_rd;
                wr_en_d = hold_wr;
                if (wait_cnt == '0) begin
                    refresh_done = 1'b1;
                    if (hold_rd && bus.app_read_req) begin
                        state_d = S_GRANT_RD;
                        grant_d = G_RD;
                    end else if (hold_wr && bus.app_write_req) begin
                        state_d = S_GRANT_WR;
                        grant_d = G_WR;
                    end else begin
                        state_d = S_IDLE;
                        rd_en_d = 1'b0;
                        wr_en_d = 1'b0;
                    end
                end else begin
                    wait_d = wait_cnt - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin register: granted engine passes through with one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sdram_command <= `SDRAM_CMD_NOP;
            bus.sdram_address <= '0;
            bus.sdram_bank    <= '0;
        end else begin
            case (state)
                S_GRANT_RD: begin
                    bus.sdram_command <= bus.rd_command;
                    bus.sdram_address <= bus.rd_address;
                    bus.sdram_bank    <= bus.rd_bank;
                end
                S_GRANT_WR: begin
                    bus.sdram_command <= bus.wr_command;
                    bus.sdram_address <= bus.wr_address;
                    bus.sdram_bank    <= bus.wr_bank;
                end
                S_PRE_ALL: begin
                    bus.sdram_command <= `SDRAM_CMD_PRE;
                    bus.sdram_address <= 12'h400;
                    bus.sdram_bank    <= '0;
                end
                S_REFRESH: begin
                    bus.sdram_command <= `SDRAM_CMD_AR;
                    bus.sdram_address <= '0;
                    bus.sdram_bank    <= '0;
                end
                default: begin
                    bus.sdram_command <= `SDRAM_CMD_NOP;
                    bus.sdram_address <= '0;
                    bus.sdram_bank    <= '0;
                end
            endcase
        end
    end

    assign bus.rd_enable    = rd_en_q;
    assign bus.wr_enable    = wr_en_q;
    assign bus.grant        = grant_q;
    assign bus.auto_refresh = pending;

`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] count_q;
    logic        late_q;
    logic        late_event;

    // A second expiry before the first refresh was serviced counts as late.
    assign late_event = expire && pending && !refresh_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            late_q  <= 1'b0;
        end else begin
            if (refresh_done) count_q <= count_q + 16'd1;
            if (late_event)   late_q  <= 1'b1;
        end
    end

    assign bus.refresh_count = count_q;
    assign bus.refresh_late  = late_q;
`else
    assign bus.refresh_count = '0;
    assign bus.refresh_late  = 1'b0;
`endif
endmodule
